// File: rtl/mem_tx_reader.sv
// ---------------------------------------------------------------------------
// mem_tx_reader
//   Drains a burst of bytes from a 32x8 byte buffer (synchronous read port)
//   into a UART transmitter. A rising edge on start samples base_addr and
//   count. Each byte is then fetched, captured and handed to the UART with a
//   tx_start / tx_busy handshake. done pulses once at the end of the burst.
//
//   Handshake (UART side): tx_start is a one-cycle request raised only in
//   SEND while tx_busy=0. The transmitter acknowledges by raising tx_busy,
//   and the byte counts as handed off when tx_busy falls again. tx_data is
//   stable from capture until the next capture.
//
//   Optional feature (macro MEM_TX_READER_LOOP_EN): when start is still high
//   at the end of a pass, base_addr and count are re-sampled and another pass
//   starts without returning to IDLE.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      burst request, rising edge acts
//   base_addr  first buffer address (sampled on start edge)
//   count      bytes to send, 0..DEPTH, larger values are clamped to DEPTH
//   mem_rd_en  buffer read strobe
//   mem_addr   buffer read address
//   mem_data   buffer read data, valid the cycle after mem_rd_en
//   tx_data    byte presented to the UART TX
//   tx_start   one-cycle request to the UART TX
//   tx_busy    UART TX busy
//   busy       burst in progress
//   done       one-cycle pulse at burst end
//   sent       bytes handed off in the current or last burst
//   state_dbg  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module mem_tx_reader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   sent,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      WAIT_HI = 3'd4,
      WAIT_LO = 3'd5,
      FINISH  = 3'd6
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state, state_d;
   logic              start_prev;
   logic              start_edge;
   logic [ADDR_W:0]   count_c;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic              load;   // latch base/count and clear sent
   logic              step;   // byte handed off: advance address and counters

   assign start_edge = start && !start_prev;
   assign count_c    = (count > DEPTH_C) ? DEPTH_C : count;

   // Strobes toward the buffer and the UART are decoded from state, so an
   // asynchronous reset clears them without waiting for a clock edge.
   assign mem_rd_en = (state == FETCH);
   assign mem_addr  = (state == FETCH) ? addr : '0;
   assign tx_start  = (state == SEND) && !tx_busy;
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: begin
            if (start_edge) begin
               load    = 1'b1;
               state_d = (count_c == '0) ? FINISH : FETCH;
            end
         end
         FETCH:   state_d = CAPTURE;
         CAPTURE: state_d = SEND;
         SEND: begin
            if (!tx_busy) state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (tx_busy) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               step    = 1'b1;
               state_d = (remaining == ONE_C) ? FINISH : FETCH;
            end
         end
         FINISH: begin
`ifdef MEM_TX_READER_LOOP_EN
            // Level-sensitive on purpose: a held start keeps the loop going.
            if (start) begin
               load    = 1'b1;
               state_d = (count_c == '0) ? IDLE : FETCH;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_prev <= 1'b0;
         addr       <= '0;
         remaining  <= '0;
         sent       <= '0;
         tx_data    <= '0;
         done       <= 1'b0;
      end else begin
         start_prev <= start;
         // done follows FINISH by one cycle, landing in the cycle where
         // busy has already dropped (or the next pass has begun).
         done       <= (state == FINISH);
         if (load) begin
            addr      <= base_addr;
            remaining <= count_c;
            sent      <= '0;
         end else if (step) begin
            addr      <= addr + 1'b1;  // wraps modulo DEPTH
            remaining <= remaining - 1'b1;
            sent      <= sent + 1'b1;
         end
         if (state == CAPTURE) begin
            tx_data <= mem_data;
         end
      end
   end

endmodule

// File: doc/mem_tx_reader.md
Name: mem_tx_reader

Overview:
- Drains a stored byte burst into the UART transmitter.
- Triggered by a rising edge on start. Reads `count` bytes from the 32x8 byte buffer through a synchronous read port, starting at base_addr.
- Hands each byte to the UART transmitter with a start/busy handshake, then pulses done.
- Sits between the byte buffer's read port and the UART TX core.

Parameters:
- DEPTH, 32, number of byte locations in the buffer.
- ADDR_W, 5, buffer address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, byte width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  burst request; only the rising edge acts.
- base_addr  input  ADDR_W  first buffer address, sampled on the start edge.
- count  input  ADDR_W+1  bytes to send (0..DEPTH), sampled on the start edge.
- mem_rd_en  output  1  buffer read strobe.
- mem_addr  output  ADDR_W  buffer read address.
- mem_data  input  DATA_W  buffer read data, valid the cycle after mem_rd_en.
- tx_data  output  DATA_W  byte presented to the UART TX.
- tx_start  output  1  one-cycle request to the UART TX.
- tx_busy  input  1  UART TX busy.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst end.
- sent  output  ADDR_W+1  bytes handed off in the current or last burst.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - mem_rd_en, mem_addr, tx_data, tx_start, busy, done and sent = 0.
  - start_prev = 0.
- Edge detect: start_prev is registered every cycle. A start edge is start=1 && start_prev=0. Edges seen outside IDLE are ignored and not queued.
- Count handling: a count value greater than DEPTH is clamped to DEPTH.
- FSM states are IDLE, FETCH, CAPTURE, SEND, WAIT_HI, WAIT_LO and FINISH.
- IDLE:
  - On a start edge: latch addr = base_addr, latch remaining = clamped count, clear sent, set busy=1.
  - Go to FINISH if the clamped count is 0, else go to FETCH.
- FETCH: mem_rd_en=1 and mem_addr=addr for exactly one cycle. Go to CAPTURE.
- CAPTURE: tx_data <= mem_data. Go to SEND.
- SEND:
  - While tx_busy=1, hold in SEND.
  - When tx_busy=0, pulse tx_start=1 for one cycle and go to WAIT_HI.
  - tx_data stays stable from CAPTURE until the next CAPTURE.
- WAIT_HI: wait for tx_busy=1 (the TX acknowledges). Go to WAIT_LO.
- WAIT_LO:
  - Wait for tx_busy=0, then do all of: sent+1, remaining-1, addr+1 (modulo DEPTH).
  - Go to FINISH if remaining was 1, else go to FETCH.
- FINISH: done=1 for one cycle and busy=0. Go to IDLE.
- Address wrap: addr increments modulo DEPTH. Example: base 30 with count 4 reads 30, 31, 0, 1.
- Latency: start edge to first mem_rd_en is 1 cycle. First tx_start follows 3 cycles after the start edge when tx_busy=0.
- Reset mid-burst: returns immediately to IDLE with all outputs 0. No done pulse. The partial burst is not resumed.
- sent holds its value after done until the next accepted start edge.

Optional Feature:
- Macro: MEM_TX_READER_LOOP_EN.
- When defined:
  - At FINISH, if start is still 1, reload addr = base_addr and remaining = clamped count (both re-sampled) and clear sent.
  - Pulse done and go to FETCH, skipping IDLE. busy stays 1.
  - The loop stops at the first FINISH with start=0.
  - A re-sampled count of 0 behaves as in the non-loop case: done, then IDLE.
- When undefined: exactly one pass per start edge. Holding start high has no further effect.

Test Plan:
- Reset, preload buffer[0..2]=0x41,0x42,0x43, start edge with base 0 and count 3, TX model busy for 10 cycles per byte -> tx_data sequence 0x41,0x42,0x43, three tx_start pulses, done once, sent=3, busy low afterwards.
- base 30, count 4, buffer[30]=0xA0, [31]=0xA1, [0]=0xB0, [1]=0xB1 -> mem_addr 30,31,0,1 and tx_data A0,A1,B0,B1.
- count 0 -> no mem_rd_en, no tx_start, done pulse 2 cycles after the edge, sent=0. count 40 -> exactly 32 bytes sent, sent=32.
- tx_busy held at 1 before the start edge for 20 cycles -> reader stays in SEND, tx_start does not assert until tx_busy drops, then pulses once.
- rst driven low asynchronously mid-burst after the 2nd byte -> all outputs 0 immediately, no done. A new start edge then sends from base with sent restarting at 0.
- Second start edge while busy -> ignored, byte count unchanged. With MEM_TX_READER_LOOP_EN, start held high with count 2 -> bytes repeat with a done per pass; releasing start ends after the current pass.
